memory_port_arbiter: RTL and testbench

MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

---
 rtl/memory_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/memory_port_arbiter.sv | 134 +++++++++++++
 tb/tb_memory_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types for the memory port arbiter: controller state and requester index.
package memory_pkg;

   // Controller state: clearing the memory, or arbitrating requests.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_ARB  = 1'b1
   } state_t;

   // Index of one of the two requesters.
   typedef logic req_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one grant per cycle, priority flips after each grant.
module rr_arbiter2
   import memory_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   req_idx_t r_ptr;

   // Grant the lone requester, or the one the pointer favours when both ask.
   always_comb begin
      // NOTE: default every output first so no path through the block infers a latch.
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (r_ptr == 1'b0) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // After a grant, point at the requester that was not served (grant[0] set -> 1).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= 1'b0;
      end else if (advance && (grant != 2'b00)) begin
         // NOTE: non-blocking so every register updates from pre-edge values.
         r_ptr <= grant[0];
      end
   end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates two requesters onto one port of an external dual-port memory and
// clears that memory to a fill value after reset or on request.
module memory_port_arbiter
   import memory_pkg::*;
#(
   parameter int   N  = 8,
   parameter int   D  = 32,
   parameter int   A  = $clog2(D),
   parameter logic RV = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   // requester 0
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic         req0_we,
   input  logic [A-1:0] req0_addr,
   input  logic [N-1:0] req0_wdata,
   output logic         rsp0_valid,
   output logic [N-1:0] rsp0_rdata,
   // requester 1
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic         req1_we,
   input  logic [A-1:0] req1_addr,
   input  logic [N-1:0] req1_wdata,
   output logic         rsp1_valid,
   output logic [N-1:0] rsp1_rdata,
   // memory port
   output logic         mem_wren,
   output logic         mem_rden,
   output logic [A-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata,
   // initialisation control
   input  logic         init_start,
   output logic         init_done
);

   localparam logic [A-1:0] LAST_ADDR = A'(D - 1);

   state_t       r_state;
   logic [A-1:0] r_fill_addr;
   logic [1:0]   r_rsp_valid;
   logic [N-1:0] r_rsp0_rdata;
   logic [N-1:0] r_rsp1_rdata;

   logic         w_arb_en;
   logic [1:0]   w_valid;
   logic [1:0]   w_grant;
   logic [1:0]   w_read;

   // Requests compete only in ARB, outside reset, and not while a re-clear is requested.
   assign w_arb_en = (r_state == ST_ARB) && !rst && !init_start;
   assign w_valid  = {req1_valid, req0_valid} & {2{w_arb_en}};
   assign w_read   = w_grant & ~{req1_we, req0_we};

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid   (w_valid),
      .advance (w_arb_en),
      .grant   (w_grant)
   );

   assign req0_ready = w_grant[0];
   assign req1_ready = w_grant[1];
   assign init_done  = (r_state == ST_ARB) && !rst;

   // Registered responses are masked while reset is held so outputs read zero at once.
   assign rsp0_valid = r_rsp_valid[0] && !rst;
   assign rsp1_valid = r_rsp_valid[1] && !rst;
   assign rsp0_rdata = rst ? '0 : r_rsp0_rdata;
   assign rsp1_rdata = rst ? '0 : r_rsp1_rdata;

   // Drive the memory port from the fill engine in INIT, or from the granted requester in ARB.
   always_comb begin
      mem_wren  = 1'b0;
      mem_rden  = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!rst) begin
         if (r_state == ST_INIT) begin
            mem_wren  = 1'b1;
            mem_addr  = r_fill_addr;
            mem_wdata = {N{RV}};
         end else if (w_grant[0]) begin
            mem_wren  = req0_we;
            mem_rden  = ~req0_we;
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
         end else if (w_grant[1]) begin
            mem_wren  = req1_we;
            mem_rden  = ~req1_we;
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
         end
      end
   end

   // State, fill address and one-cycle-latency read responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_INIT;
         r_fill_addr  <= '0;
         r_rsp_valid  <= 2'b00;
         r_rsp0_rdata <= '0;
         r_rsp1_rdata <= '0;
      end else begin
         r_rsp_valid <= w_read;
         if (w_read[0]) r_rsp0_rdata <= mem_rdata;
         if (w_read[1]) r_rsp1_rdata <= mem_rdata;

         case (r_state)
            ST_INIT: begin
               if (r_fill_addr == LAST_ADDR) begin
                  r_state     <= ST_ARB;
                  r_fill_addr <= '0;
               end else begin
                  r_fill_addr <= r_fill_addr + A'(1);
               end
            end
            ST_ARB: begin
               if (init_start) begin
                  r_state     <= ST_INIT;
                  r_fill_addr <= '0;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: directed stimulus pushes expected read
// responses, a negedge monitor pops and compares them.
module tb_memory_port_arbiter;

   localparam int N = 8;
   localparam int D = 32;
   localparam int A = 5;

   typedef struct {
      logic [N-1:0] data;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0, req0_we = 1'b0;
   logic [A-1:0] req0_addr = '0;
   logic [N-1:0] req0_wdata = '0;
   logic         req1_valid = 1'b0, req1_we = 1'b0;
   logic [A-1:0] req1_addr = '0;
   logic [N-1:0] req1_wdata = '0;
   logic         init_start = 1'b0;
   logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [N-1:0] rsp0_rdata, rsp1_rdata;
   logic         mem_wren, mem_rden, init_done;
   logic [A-1:0] mem_addr;
   logic [N-1:0] mem_wdata, mem_rdata;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   n_fill;

   logic [N-1:0] mem [D];

   memory_port_arbiter #(.N(N), .D(D), .A(A), .RV(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .mem_wren   (mem_wren),
      .mem_rden   (mem_rden),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .init_start (init_start),
      .init_done  (init_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // External memory model: synchronous write, combinational read.
   initial for (int i = 0; i < D; i++) mem[i] = 8'hEE;
   always @(posedge clk) if (mem_wren) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Response monitor: every valid response must match the oldest expectation, one cycle after its grant.
   always @(negedge clk) begin
      if (rsp0_valid || rsp1_valid)
         check("rsp_excl", 32'(rsp0_valid && rsp1_valid), 32'd0);
      if (rsp0_valid) begin
         if (q0.size() == 0) check("rsp0_unexpected", 32'(q0.size()), 32'd1);
         else begin
            e0 = q0.pop_front();
            check("rsp0_rdata", 32'(rsp0_rdata), 32'(e0.data));
            check("rsp0_latency", 32'(cyc), 32'(e0.cyc + 1));
         end
      end
      if (rsp1_valid) begin
         if (q1.size() == 0) check("rsp1_unexpected", 32'(q1.size()), 32'd1);
         else begin
            e1 = q1.pop_front();
            check("rsp1_rdata", 32'(rsp1_rdata), 32'(e1.data));
            check("rsp1_latency", 32'(cyc), 32'(e1.cyc + 1));
         end
      end
   end

   // One ARB cycle: drive both requesters, check grant and memory port, queue expected read data.
   task automatic issue(input logic v0, input logic we0, input logic [A-1:0] a0, input logic [N-1:0] d0,
                        input logic v1, input logic we1, input logic [A-1:0] a1, input logic [N-1:0] d1,
                        input logic [1:0] exp_g, input logic [N-1:0] exp_rd, input bit push);
      logic         xw, xr;
      logic [A-1:0] xa;
      logic [N-1:0] xd;
      req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
      req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
      xw = 1'b0; xr = 1'b0; xa = '0; xd = '0;
      if (exp_g[0])      begin xw = we0; xr = ~we0; xa = a0; xd = d0; end
      else if (exp_g[1]) begin xw = we1; xr = ~we1; xa = a1; xd = d1; end
      @(negedge clk);
      check("ready", 32'({req1_ready, req0_ready}), 32'(exp_g));
      check("mem_wren", 32'(mem_wren), 32'(xw));
      check("mem_rden", 32'(mem_rden), 32'(xr));
      check("mem_addr", 32'(mem_addr), 32'(xa));
      check("mem_wdata", 32'(mem_wdata), 32'(xd));
      if (push && xr) begin
         if (exp_g[0]) q0.push_back('{data: exp_rd, cyc: cyc});
         else          q1.push_back('{data: exp_rd, cyc: cyc});
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   // Walk an INIT phase from its first cycle; requests are held to prove they stall.
   task automatic run_fill(input int stop_after, input int pulse_at, output int n);
      int bad;
      bit done;
      bad = 0; n = 0; done = 0;
      req0_we = 1'b0; req0_addr = 5'd5; req1_we = 1'b1; req1_addr = 5'd5; req1_wdata = 8'h99;
      for (int i = 0; i < D + 8; i++) begin
         init_start = (i == pulse_at);
         req0_valid = (i < D - 4);
         req1_valid = (i < D - 4);
         @(negedge clk);
         if (init_done) begin done = 1; break; end
         if (mem_wren !== 1'b1 || mem_rden !== 1'b0 || mem_addr !== A'(n) ||
             mem_wdata !== 8'h00 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
            bad++;
         n++;
         @(posedge clk); #1;
         if (n == stop_after) break;
      end
      init_start = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      if (done) begin @(posedge clk); #1; end
      check("fill_seq_errors", 32'(bad), 32'd0);
   endtask

   task automatic check_rst_outputs(input string tag);
      @(negedge clk);
      check({tag, "_flags"}, 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_wren, mem_rden, init_done}), 32'd0);
      check({tag, "_addr_wdata"}, 32'({mem_addr, mem_wdata}), 32'd0);
      check({tag, "_rdata"}, 32'({rsp0_rdata, rsp1_rdata}), 32'd0);
   endtask

   initial begin
      // reset state
      check_rst_outputs("rst0");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      run_fill(1000, -1, n_fill);
      check("fill_len_first", 32'(n_fill), 32'd32);
      check("init_done_after_fill", 32'(init_done), 32'd1);

      // write then read by req0 (pointer 0 -> 1 -> 1)
      issue(1, 1, 5'd5, 8'hA5, 0, 0, 5'd0, 8'h00, 2'b01, 8'h00, 1);
      issue(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00, 2'b01, 8'hA5, 1);
      // req1 alone writes addr 7 (pointer -> 0)
      issue(0, 0, 5'd0, 8'h00, 1, 1, 5'd7, 8'h77, 2'b10, 8'h00, 1);
      // both hold reads for four cycles: grants 0,1,0,1
      issue(1, 0, 5'd5, 8'h00, 1, 0, 5'd7, 8'h00, 2'b01, 8'hA5, 1);
      issue(1, 0, 5'd7, 8'h00, 1, 0, 5'd7, 8'h00, 2'b10, 8'h77, 1);
      issue(1, 0, 5'd7, 8'h00, 1, 0, 5'd5, 8'h00, 2'b01, 8'h77, 1);
      issue(1, 0, 5'd0, 8'h00, 1, 0, 5'd5, 8'h00, 2'b10, 8'hA5, 1);
      // write by req0 then read of same address by req1 next cycle
      issue(1, 1, 5'd3, 8'h3C, 0, 0, 5'd0, 8'h00, 2'b01, 8'h00, 1);
      issue(0, 0, 5'd0, 8'h00, 1, 0, 5'd3, 8'h00, 2'b10, 8'h3C, 1);
      // idle ARB cycle: port quiet
      issue(0, 0, 5'd9, 8'h12, 0, 1, 5'd9, 8'h34, 2'b00, 8'h00, 1);

      // init_start with req1 valid: no grant, then a full re-clear (pulse during INIT ignored)
      init_start = 1'b1; req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 5'd5;
      @(negedge clk);
      check("init_start_no_grant", 32'({req1_ready, req0_ready, mem_wren, mem_rden}), 32'd0);
      check("init_start_done_high", 32'(init_done), 32'd1);
      @(posedge clk); #1;
      init_start = 1'b0; req1_valid = 1'b0;
      run_fill(1000, 5, n_fill);
      check("fill_len_reinit", 32'(n_fill), 32'd32);
      issue(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00, 2'b01, 8'h00, 1);
      issue(0, 0, 5'd0, 8'h00, 1, 0, 5'd3, 8'h00, 2'b10, 8'h00, 1);

      // reset right after a read grant: the pending response is dropped
      issue(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00, 2'b01, 8'h00, 0);
      rst = 1'b1;
      check_rst_outputs("rst_arb");
      @(posedge clk); #1;
      rst = 1'b0;
      run_fill(1000, -1, n_fill);
      check("fill_len_after_arb_rst", 32'(n_fill), 32'd32);

      // reset at fill address 10 restarts the fill from 0
      init_start = 1'b1;
      @(posedge clk); #1;
      init_start = 1'b0;
      run_fill(10, -1, n_fill);
      check("fill_partial_len", 32'(n_fill), 32'd10);
      rst = 1'b1;
      check_rst_outputs("rst_fill");
      @(posedge clk); #1;
      rst = 1'b0;
      run_fill(1000, -1, n_fill);
      check("fill_len_after_fill_rst", 32'(n_fill), 32'd32);

      repeat (3) @(posedge clk);
      #1;
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
